alt_enable: RTL

- Upstream partner of the ALT disable stage in the channel unit.
- Walks the ALT's channel list in RAM and, for each channel, performs the enable step:
  - empty channel: registers the receiver's PID on the channel;
  - channel holding another PID: a sender is already waiting, so the ALT is ready.
- Produces the ready summary that the scheduler uses to decide whether to deschedule the receiver before the disable pass runs.

---
 rtl/alt_enable_pkg.sv | 15 +
 rtl/alt_enable.sv | 92 +++++++++
 2 files changed

// File: rtl/alt_enable_pkg.sv
// alt_enable_pkg: shared widths, RAM mode codes, empty-PID marker and walk states
package alt_enable_pkg;
  localparam int ADDRESS_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam logic RAM_READ = 1'b0;
  localparam logic RAM_WRITE = 1'b1;
  localparam int EMPTY_PID = 0;
  typedef enum logic [2:0] {
    IDLE,
    LIST_READ,
    CHAN_READ,
    CHECK,
    DONE
  } state_t;
endpackage

// File: rtl/alt_enable.sv
// alt_enable: walks an ALT channel list, parks rxPid on empty channels and summarises waiting senders
//   clk, reset (sync, active-low)   enabled: level start, low returns to idle
//   finished: all channels processed, held until enabled falls
//   address/readWriteMode/dataIn: RAM request (combinational); dataOut: RAM read data, one cycle late
//   listBase/channelCount: channel-address list; rxPid: receiving process
//   altReady/readyChannel/readyCount: ready summary for the scheduler
module alt_enable
  import alt_enable_pkg::*;
#(
  parameter int addrBits = ADDRESS_BITS,
  parameter int dataBits = DATA_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabled,
  output logic                finished,
  output logic [addrBits-1:0] address,
  output logic                readWriteMode,
  input  logic [dataBits-1:0] dataOut,
  output logic [dataBits-1:0] dataIn,
  input  logic [addrBits-1:0] listBase,
  input  logic [addrBits-1:0] channelCount,
  input  logic [addrBits-1:0] rxPid,
  output logic                altReady,
  output logic [addrBits-1:0] readyChannel,
  output logic [addrBits-1:0] readyCount
);
  state_t state;
  logic [addrBits-1:0] index;
  logic [addrBits-1:0] rChannel;
  logic [addrBits-1:0] pid;
  logic isEmpty;
  logic isWrite;
  logic isReady;
  logic unusedHigh;
  assign unusedHigh = ^dataOut[dataBits-1:addrBits];
  always_comb begin
    pid = dataOut[addrBits-1:0];
    isEmpty = pid == addrBits'(EMPTY_PID);
    isWrite = state == CHECK && isEmpty;
    isReady = !isEmpty && pid != rxPid;
    address = state == LIST_READ ? listBase + index :
              state == CHAN_READ ? pid :
              state == CHECK     ? rChannel : '0;
    readWriteMode = isWrite ? RAM_WRITE : RAM_READ;
    dataIn = isWrite ? {{(dataBits-addrBits){1'b0}}, rxPid} : '0;
  end
  // finished is raised on the edge that enters DONE so the count-0 case completes in one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      index <= '0;
      rChannel <= '0;
      finished <= 1'b0;
      altReady <= 1'b0;
      readyChannel <= '0;
      readyCount <= '0;
    end else if (!enabled) begin
      state <= IDLE;
      index <= '0;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          altReady <= 1'b0;
          readyChannel <= '0;
          readyCount <= '0;
          index <= '0;
          finished <= channelCount == '0;
          state <= channelCount == '0 ? DONE : LIST_READ;
        end
        LIST_READ: state <= CHAN_READ;
        CHAN_READ: begin
          rChannel <= pid;
          state <= CHECK;
        end
        CHECK: begin
          if (isReady) begin
            if (readyCount != '1) readyCount <= readyCount + 1'b1;
            if (!altReady) readyChannel <= rChannel;
            altReady <= 1'b1;
          end
          index <= index + 1'b1;
          finished <= index == channelCount - 1'b1;
          state <= index == channelCount - 1'b1 ? DONE : LIST_READ;
        end
        DONE: finished <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
